tensor_core_register_file_streamer: RTL and testbench

Serial front end for the tensor core register file. LOAD mode takes a byte stream over a valid/ready handshake and drives the register file's single-register write port, filling addresses 0..NUMBER_OF_REGISTERS-1 in order. DUMP mode walks the register file's single-register read port and emits every register as a valid/ready output stream. It sits between the host/IO side and the register file, and is the serial counterpart to the tensor core's bulk access.

---
 rtl/tensor_core_register_file_streamer.sv | 177 +++++++++++++++++
 tb/tb_tensor_core_register_file_streamer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_core_register_file_streamer.sv
// -----------------------------------------------------------------------------
// tensor_core_register_file_streamer
//
// Serial front end for the tensor core register file.
//   LOAD: accepts NUMBER_OF_REGISTERS bytes over a valid/ready input stream.
//         Each accepted byte is written to the register file in address order
//         0..NUMBER_OF_REGISTERS-1.
//   DUMP: reads addresses 0..NUMBER_OF_REGISTERS-1 through the combinational
//         read port. Each value is emitted on a registered valid/ready output
//         stream.
//
// Handshake semantics (both streams): a byte transfers on a rising clock edge
// exactly when valid and ready are both high in that cycle. A producer holding
// valid high keeps its data stable until that transfer happens.
//
// Ports:
//   clock_in, reset_in            clock; synchronous active-high reset
//   load_start_in, dump_start_in  start requests, honoured only in IDLE
//                                 (load wins when both are high)
//   stream_in_*                   load byte stream (sink side)
//   stream_out_*                  dump byte stream (source side, registered)
//   rf_write_*                    register file single-register write port
//   rf_read_address_out           register file read address
//   rf_read_data_in               register file read data (combinational)
//   busy_out                      high whenever not IDLE
//   done_out                      one-cycle pulse on load/dump completion
//   state_debug_out               current FSM state (0 IDLE, 1 LOAD, 2 DUMP)
// -----------------------------------------------------------------------------
module tensor_core_register_file_streamer #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 8,
  localparam int AW                 = $clog2(NUMBER_OF_REGISTERS),
  localparam int PW                 = AW + 1
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         load_start_in,
  input  logic                         dump_start_in,
  input  logic signed [DATA_WIDTH-1:0] stream_in_data_in,
  input  logic                         stream_in_valid_in,
  output logic                         stream_in_ready_out,
  output logic signed [DATA_WIDTH-1:0] stream_out_data_out,
  output logic                         stream_out_valid_out,
  input  logic                         stream_out_ready_in,
  output logic                         rf_write_enable_out,
  output logic [AW-1:0]                rf_write_address_out,
  output logic signed [DATA_WIDTH-1:0] rf_write_data_out,
  output logic [AW-1:0]                rf_read_address_out,
  input  logic signed [DATA_WIDTH-1:0] rf_read_data_in,
  output logic                         busy_out,
  output logic                         done_out,
  output logic [1:0]                   state_debug_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2
  } state_e;

  // Pointers are one bit wider than the address so they can reach
  // NUMBER_OF_REGISTERS, which marks "all registers issued".
  localparam logic [PW-1:0] PTR_END  = PW'(NUMBER_OF_REGISTERS);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUMBER_OF_REGISTERS - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  state_e                       state_q, state_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         done_q, done_d;

  logic in_load;
  logic in_dump;
  logic in_handshake;

  assign in_load      = (state_q == ST_LOAD);
  assign in_dump      = (state_q == ST_DUMP);
  assign in_handshake = in_load & stream_in_valid_in;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_start_in) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end else if (dump_start_in) begin
          state_d  = ST_DUMP;
          rd_ptr_d = '0;
        end
      end

      ST_LOAD: begin
        if (in_handshake) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (wr_ptr_q == PTR_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_DUMP: begin
        // Refill the output register whenever it is empty or being drained,
        // as long as registers remain. Once every register has been issued,
        // the final handshake empties the register and ends the dump.
        if ((rd_ptr_q < PTR_END) && (!out_valid_q || stream_out_ready_in)) begin
          out_data_d  = rf_read_data_in;
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
        end else if (out_valid_q && stream_out_ready_in) begin
          out_valid_d = 1'b0;
          if (rd_ptr_q == PTR_END) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stream_in_ready_out = in_load;

  // The write is gated by reset so that an aborting reset cycle can never
  // land a stray byte in the register file.
  assign rf_write_enable_out  = in_handshake & ~reset_in;
  assign rf_write_address_out = in_load ? wr_ptr_q[AW-1:0] : '0;
  assign rf_write_data_out    = in_load ? stream_in_data_in : '0;

  assign rf_read_address_out  = in_dump ? rd_ptr_q[AW-1:0] : '0;

  assign stream_out_data_out  = out_data_q;
  assign stream_out_valid_out = out_valid_q;
  assign busy_out             = (state_q != ST_IDLE);
  assign done_out             = done_q;
  assign state_debug_out      = state_q;

endmodule

// File: tb/tb_tensor_core_register_file_streamer.sv
module tb_tensor_core_register_file_streamer;

  localparam int N  = 32;
  localparam int W  = 8;
  localparam int AW = $clog2(N);
  localparam int BUDGET = 400;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_in;
  logic          load_start_in;
  logic          dump_start_in;
  logic [W-1:0]  stream_in_data_in;
  logic          stream_in_valid_in;
  logic          stream_in_ready_out;
  logic [W-1:0]  stream_out_data_out;
  logic          stream_out_valid_out;
  logic          stream_out_ready_in;
  logic          rf_write_enable_out;
  logic [AW-1:0] rf_write_address_out;
  logic [W-1:0]  rf_write_data_out;
  logic [AW-1:0] rf_read_address_out;
  logic [W-1:0]  rf_read_data_in;
  logic          busy_out;
  logic          done_out;
  logic [1:0]    state_debug_out;

  tensor_core_register_file_streamer #(
    .NUMBER_OF_REGISTERS(N),
    .DATA_WIDTH(W)
  ) dut (
    .clock_in            (clk),
    .reset_in            (reset_in),
    .load_start_in       (load_start_in),
    .dump_start_in       (dump_start_in),
    .stream_in_data_in   (stream_in_data_in),
    .stream_in_valid_in  (stream_in_valid_in),
    .stream_in_ready_out (stream_in_ready_out),
    .stream_out_data_out (stream_out_data_out),
    .stream_out_valid_out(stream_out_valid_out),
    .stream_out_ready_in (stream_out_ready_in),
    .rf_write_enable_out (rf_write_enable_out),
    .rf_write_address_out(rf_write_address_out),
    .rf_write_data_out   (rf_write_data_out),
    .rf_read_address_out (rf_read_address_out),
    .rf_read_data_in     (rf_read_data_in),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .state_debug_out     (state_debug_out)
  );

  // Register file environment the DUT talks to.
  logic [W-1:0] rf_mem [N];
  assign rf_read_data_in = rf_mem[rf_read_address_out];
  always @(posedge clk) begin
    if (rf_write_enable_out) rf_mem[rf_write_address_out] <= rf_write_data_out;
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_rf [N];   // what the register file should hold
  logic [W-1:0] exp_q[$];     // bytes a dump should emit, in order
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    load_start_in       = 1'b0;
    dump_start_in       = 1'b0;
    stream_in_valid_in  = 1'b0;
    stream_in_data_in   = '0;
    stream_out_ready_in = 1'b0;
  endtask

  // mode 0: valid high, data k; mode 1: valid 1,0,..., data -(k+1);
  // mode 2: random valid and data.
  task automatic load_stream(input int mode);
    int k = 0;
    int cyc = 0;
    int done_pulses = 0;
    logic v;
    logic [W-1:0] b;
    @(negedge clk);
    load_start_in = 1'b1;
    #1 check("load_busy_before", busy_out, 0);
    @(negedge clk);
    load_start_in = 1'b0;
    while (k < N && cyc < BUDGET) begin
      case (mode)
        0:       begin v = 1'b1;             b = W'(k);                  end
        1:       begin v = (cyc % 2 == 0);    b = W'(-(k + 1));           end
        default: begin v = 1'($urandom_range(0, 1)); b = W'($urandom_range(0, 255)); end
      endcase
      stream_in_valid_in = v;
      stream_in_data_in  = b;
      #1;
      check("load_ready", stream_in_ready_out, 1);
      check("load_busy", busy_out, 1);
      check("load_we", rf_write_enable_out, v);
      if (done_out) done_pulses++;
      if (v) begin
        check("load_waddr", rf_write_address_out, k);
        check("load_wdata", rf_write_data_out, b);
        exp_rf[k] = b;
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    check("load_timeout", k, N);
    stream_in_valid_in = 1'b1;   // extra valid must not cause a write
    stream_in_data_in  = 8'h5a;
    #1;
    check("load_done", done_out, 1);
    check("load_busy_end", busy_out, 0);
    check("load_ready_end", stream_in_ready_out, 0);
    check("load_we_end", rf_write_enable_out, 0);
    check("load_done_pulses", done_pulses, 0);
    @(negedge clk);
    stream_in_valid_in = 1'b0;
    #1 check("load_done_clear", done_out, 0);
  endtask

  // mode 0: ready high; mode 1: ready 1,0,0,...; mode 2: random ready.
  task automatic dump_stream(input int mode);
    int got = 0;
    int cyc = 0;
    logic stall = 1'b0;
    logic [W-1:0] held = '0;
    logic [W-1:0] e;
    exp_q = {};
    for (int i = 0; i < N; i++) exp_q.push_back(exp_rf[i]);
    @(negedge clk);
    dump_start_in = 1'b1;
    #1 check("dump_valid_before", stream_out_valid_out, 0);
    @(negedge clk);                // edge E0 has passed
    dump_start_in = 1'b0;
    stream_out_ready_in = 1'b1;
    #1;
    check("dump_busy", busy_out, 1);
    check("dump_first_latency", stream_out_valid_out, 0);
    while (got < N && cyc < BUDGET) begin
      @(negedge clk);
      case (mode)
        0:       stream_out_ready_in = 1'b1;
        1:       stream_out_ready_in = (cyc % 3 == 0);
        default: stream_out_ready_in = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("dump_no_write", rf_write_enable_out, 0);
      if (mode == 0) check("dump_streaming", stream_out_valid_out, 1);
      if (stall) begin
        check("dump_hold_valid", stream_out_valid_out, 1);
        check("dump_hold_data", stream_out_data_out, held);
      end
      if (stream_out_valid_out && stream_out_ready_in) begin
        e = exp_q.pop_front();
        check("dump_data", stream_out_data_out, e);
        got++;
      end
      stall = stream_out_valid_out && !stream_out_ready_in;
      held  = stream_out_data_out;
      cyc++;
    end
    check("dump_timeout", got, N);
    @(negedge clk);
    stream_out_ready_in = 1'b0;
    #1;
    check("dump_done", done_out, 1);
    check("dump_valid_end", stream_out_valid_out, 0);
    check("dump_busy_end", busy_out, 0);
    @(negedge clk);
    #1 check("dump_done_clear", done_out, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    reset_in = 1'b1;
    @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      #1;
      check("rst_ready", stream_in_ready_out, 0);
      check("rst_we", rf_write_enable_out, 0);
      check("rst_waddr", rf_write_address_out, 0);
      check("rst_wdata", rf_write_data_out, 0);
      check("rst_raddr", rf_read_address_out, 0);
      check("rst_out_valid", stream_out_valid_out, 0);
      check("rst_out_data", stream_out_data_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_done", done_out, 0);
    end
    reset_in = 1'b0;

    load_stream(0);
    dump_stream(0);
    load_stream(1);
    dump_stream(1);
    load_stream(2);
    dump_stream(2);

    // Reset in the middle of a load.
    @(negedge clk);
    load_start_in = 1'b1;
    @(negedge clk);
    load_start_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      stream_in_valid_in = 1'b1;
      stream_in_data_in  = W'($urandom_range(0, 255));
      exp_rf[k] = stream_in_data_in;
      #1 check("abort_we", rf_write_enable_out, 1);
      @(negedge clk);
    end
    reset_in           = 1'b1;
    stream_in_valid_in = 1'b1;
    stream_in_data_in  = ~exp_rf[10];
    #1 check("abort_no_write", rf_write_enable_out, 0);
    @(negedge clk);
    reset_in           = 1'b0;
    stream_in_valid_in = 1'b0;
    #1;
    check("abort_ready", stream_in_ready_out, 0);
    check("abort_busy", busy_out, 0);
    check("abort_done", done_out, 0);

    // Both starts together: load wins.
    @(negedge clk);
    load_start_in = 1'b1;
    dump_start_in = 1'b1;
    @(negedge clk);
    load_start_in = 1'b0;
    dump_start_in = 1'b0;
    #1;
    check("both_ready", stream_in_ready_out, 1);
    check("both_state", state_debug_out, 1);
    @(negedge clk);
    #1 check("both_out_valid", stream_out_valid_out, 0);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;

    // Contents must reflect the partial load on top of the earlier data.
    dump_stream(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
